// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: UART transmitter with a word FIFO ahead of the serialiser.
// Frame format (data bits, parity, stop bits) is fixed at elaboration.
module uart_tx_fifo_param #(
  parameter int SYS_CLK_FRE = 50_000_000,
  parameter int BPS         = 9_600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BPS_CNT = SYS_CLK_FRE / BPS;
  localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (BPS_CNT < 2) begin : g_bad_bps_cnt
    $error("uart_tx_fifo_param: SYS_CLK_FRE/BPS must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic [LW-1:0]        level_d;
  logic                 ready_q;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [3:0]           idx_q;
  logic [3:0]           idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_q;
  logic                 par_d;
  logic                 txd_q;
  logic                 txd_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 cnt_last;

  assign push       = tx_valid && ready_q;
  assign head       = mem[rd_ptr_q];
  assign cnt_last   = (cnt_q == CW'(BPS_CNT - 1));

  assign tx_ready   = ready_q;
  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_level = level_q;

  // FIFO storage; contents need no reset, the pointers define validity
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  // next FIFO level from simultaneous push/pop
  always_comb begin
    level_d = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  // FIFO pointers, level and registered ready
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ready_q <= (level_d != LW'(FIFO_DEPTH));
    end
  end

  // frame sequencing, pop decisions and next line level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (PARITY == 1) ? ~^head : ^head;
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (cnt_last) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (cnt_last) begin
          shift_d = shift_q >> 1;
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        txd_d = par_q;
        if (cnt_last) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (cnt_last) begin
          if (idx_q == 4'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (level_q != '0) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (PARITY == 1) ? ~^head : ^head;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // busy covers the pop cycle, the frame on the line and any queued word
  always_comb begin
    busy_d = (state_q != S_IDLE) || (state_d != S_IDLE) || (level_d != '0);
  end

  // FSM registers and registered line/busy outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: four frame formats driven side by side,
// checked every cycle against a timeline model plus literal frames.
module tb_uart_tx_fifo_param;

  localparam int BC = 10;
  localparam int N  = 4;
  localparam int DB [N] = '{8, 8, 8, 7};
  localparam int PA [N] = '{0, 2, 1, 0};
  localparam int SB [N] = '{1, 1, 2, 1};

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [8:0] dat [N];
  logic       vld [N];
  logic       rdy [N];
  logic       txd [N];
  logic       bsy [N];
  logic [2:0] lvl [N];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int t = 0;

  logic [8:0] mq [N][$];
  logic [8:0] mw [N];
  int         mf [N];
  logic       e_txd [N];
  logic       e_bsy [N];
  logic       e_rdy [N];
  int         e_lvl [N];

  always #5 sys_clk = ~sys_clk;

  uart_tx_fifo_param #(
    .SYS_CLK_FRE(1_000_000), .BPS(100_000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8n1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .tx_data(dat[0][7:0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .uart_txd(txd[0]), .tx_busy(bsy[0]), .fifo_level(lvl[0])
  );

  uart_tx_fifo_param #(
    .SYS_CLK_FRE(1_000_000), .BPS(100_000),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8e1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .tx_data(dat[1][7:0]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .uart_txd(txd[1]), .tx_busy(bsy[1]), .fifo_level(lvl[1])
  );

  uart_tx_fifo_param #(
    .SYS_CLK_FRE(1_000_000), .BPS(100_000),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_8o2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .tx_data(dat[2][7:0]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .uart_txd(txd[2]), .tx_busy(bsy[2]), .fifo_level(lvl[2])
  );

  uart_tx_fifo_param #(
    .SYS_CLK_FRE(1_000_000), .BPS(100_000),
    .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_7n1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .tx_data(dat[3][6:0]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
    .uart_txd(txd[3]), .tx_busy(bsy[3]), .fifo_level(lvl[3])
  );

  function automatic int flen(int i);
    return (1 + DB[i] + ((PA[i] != 0) ? 1 : 0) + SB[i]) * BC;
  endfunction

  // line level of bit k of a frame carrying word w
  function automatic logic fbit(int i, logic [8:0] w, int k);
    logic p;
    p = ^w;
    if (k == 0) return 1'b0;
    if (k <= DB[i]) return w[k-1];
    if (PA[i] != 0 && k == DB[i] + 1) return (PA[i] == 2) ? p : ~p;
    return 1'b1;
  endfunction

  // timeline model: a frame starting on the line at edge F occupies
  // edges F..F+len-1; the next word may leave at edge F+len-1 or later
  initial begin : model
    int sz;
    bit on_l;
    bit pop_l;
    bit push_l;
    for (int i = 0; i < N; i++) begin
      mf[i] = -100000;
      mw[i] = '0;
      e_txd[i] = 1'b1;
      e_bsy[i] = 1'b0;
      e_rdy[i] = 1'b1;
      e_lvl[i] = 0;
    end
    forever begin
      @(posedge sys_clk);
      t++;
      for (int i = 0; i < N; i++) begin
        if (sys_rst) begin
          mq[i].delete();
          mf[i] = -100000;
          e_txd[i] = 1'b1;
          e_bsy[i] = 1'b0;
          e_rdy[i] = 1'b1;
          e_lvl[i] = 0;
        end else begin
          sz = mq[i].size();
          on_l = (t >= mf[i]) && (t < mf[i] + flen(i));
          e_txd[i] = on_l ? fbit(i, mw[i], (t - mf[i]) / BC) : 1'b1;
          pop_l = (sz > 0) && (t >= mf[i] + flen(i) - 1);
          push_l = (vld[i] === 1'b1) && (sz < 4);
          if (pop_l) begin
            mw[i] = mq[i].pop_front();
            mf[i] = t + 1;
          end
          if (push_l) mq[i].push_back(dat[i] & 9'((1 << DB[i]) - 1));
          e_lvl[i] = mq[i].size();
          e_rdy[i] = (e_lvl[i] < 4);
          e_bsy[i] = on_l || pop_l || (e_lvl[i] != 0);
        end
      end
    end
  end

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0d: got %0h want %0h", nm, i, t, act, exp);
    end
  endtask

  task automatic send_frame(input int i, input logic [8:0] w,
                            input int nb, input logic [11:0] exp);
    int c;
    logic [11:0] got;
    got = '0;
    dat[i] = w;
    vld[i] = 1'b1;
    @(negedge sys_clk);
    vld[i] = 1'b0;
    c = 0;
    while (txd[i] === 1'b1 && c < 50) begin
      @(negedge sys_clk);
      c++;
    end
    chk("latency", i, c, 2);
    for (int k = 0; k < nb; k++) begin
      repeat ((k == 0) ? 5 : 10) @(negedge sys_clk);
      got[k] = txd[i];
    end
    chk("frame", i, got, exp);
    repeat (4) @(negedge sys_clk);
    chk("busy_last", i, bsy[i], 1);
    @(negedge sys_clk);
    chk("busy_fall", i, bsy[i], 0);
    chk("idle_txd", i, txd[i], 1);
    @(negedge sys_clk);
  endtask

  task automatic burst_test();
    bit saw_full;
    int acc;
    int guard;
    int c;
    logic r;
    logic [9:0] fr;
    saw_full = 1'b0;
    acc = 0;
    guard = 0;
    fork
      begin
        while (acc < 6 && guard < 2000) begin
          dat[0] = 9'(8'h11 + acc);
          vld[0] = 1'b1;
          if (rdy[0] === 1'b0 && lvl[0] === 3'd4) saw_full = 1'b1;
          r = rdy[0];
          @(negedge sys_clk);
          if (r === 1'b1) acc++;
          guard++;
        end
        vld[0] = 1'b0;
      end
      begin
        c = 0;
        while (txd[0] === 1'b1 && c < 100) begin
          @(negedge sys_clk);
          c++;
        end
        chk("burst_start", 0, (c < 100), 1);
        for (int j = 0; j < 6; j++) begin
          for (int k = 0; k < 10; k++) begin
            repeat ((j == 0 && k == 0) ? 5 : 10) @(negedge sys_clk);
            fr[k] = txd[0];
          end
          chk("burst_frame", j, fr, {1'b1, 8'(8'h11 + j), 1'b0});
        end
      end
    join
    chk("burst_accepted", 0, acc, 6);
    chk("burst_full_seen", 0, saw_full, 1);
    c = 0;
    while (bsy[0] !== 1'b0 && c < 200) begin
      @(negedge sys_clk);
      c++;
    end
    chk("burst_idle", 0, (c < 200), 1);
    @(negedge sys_clk);
  endtask

  task automatic reset_test();
    bit stray;
    dat[0] = 9'h0FF;
    vld[0] = 1'b1;
    @(negedge sys_clk);
    dat[0] = 9'h0AA;
    @(negedge sys_clk);
    dat[0] = 9'h055;
    @(negedge sys_clk);
    vld[0] = 1'b0;
    chk("rst_frame_start", 0, txd[0], 0);
    repeat (44) @(negedge sys_clk);
    chk("rst_pre_txd", 0, txd[0], 1);
    chk("rst_pre_level", 0, lvl[0], 2);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_txd", 0, txd[0], 1);
    chk("rst_busy", 0, bsy[0], 0);
    chk("rst_level", 0, lvl[0], 0);
    chk("rst_ready", 0, rdy[0], 1);
    stray = 1'b0;
    repeat (300) begin
      @(negedge sys_clk);
      if (txd[0] !== 1'b1 || bsy[0] !== 1'b0) stray = 1'b1;
    end
    chk("rst_no_frames", 0, stray, 0);
  endtask

  task automatic random_test();
    int rate;
    int c;
    bit any;
    for (int n = 0; n < 4000; n++) begin
      @(negedge sys_clk);
      rate = (n < 2000) ? 4 : 1;
      for (int i = 0; i < N; i++) begin
        vld[i] = ($urandom_range(0, 99) < rate);
        dat[i] = 9'($urandom);
      end
      sys_rst = ($urandom_range(0, 1999) == 0);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    c = 0;
    any = 1'b1;
    while (any && c < 2000) begin
      @(negedge sys_clk);
      c++;
      any = 1'b0;
      for (int i = 0; i < N; i++) if (bsy[i] !== 1'b0) any = 1'b1;
    end
    chk("drain", 0, (c < 2000), 1);
  endtask

  initial begin : main
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    sys_rst = 1'b1;
    chk_en = 1'b1;
    fork
      forever begin
        @(negedge sys_clk);
        if (chk_en) begin
          for (int i = 0; i < N; i++) begin
            chk("txd", i, txd[i], e_txd[i]);
            chk("busy", i, bsy[i], e_bsy[i]);
            chk("level", i, lvl[i], e_lvl[i]);
            chk("ready", i, rdy[i], e_rdy[i]);
          end
        end
      end
    join_none
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < N; i++) begin
      chk("reset_txd", i, txd[i], 1);
      chk("reset_busy", i, bsy[i], 0);
      chk("reset_level", i, lvl[i], 0);
      chk("reset_ready", i, rdy[i], 1);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    send_frame(0, 9'h0A5, 10, 12'h34A);
    send_frame(1, 9'h007, 11, 12'h60E);
    send_frame(1, 9'h00F, 11, 12'h41E);
    send_frame(2, 9'h003, 12, 12'hE06);
    send_frame(3, 9'h041, 9, 12'h182);
    burst_test();
    reset_test();
    random_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
